jk_flip_flop: RTL and testbench

//  - Positive-edge JK flip-flop, vectorised: WIDTH independent JK bits.
//  - Provides true and complementary outputs.
//  - Leaf storage cell for control/state logic: counters, toggle flags, handshake latches.
//  - One clock domain; asynchronous active-high reset.

---
 rtl/jk_pkg.sv | 22 ++
 rtl/jk_ff_bit.sv | 22 ++
 rtl/jk_flip_flop.sv | 31 +++
 tb/tb_jk_flip_flop.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: {j,k} mode codes and the per-bit next-state function.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // An X or Z on j/k matches no code, so it deliberately yields X instead of being masked.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = 1'bx;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_ff_bit.sv
// Single-bit positive-edge JK storage cell with asynchronous active-high reset.
module jk_ff_bit
    import jk_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= jk_next(q, j, k);
        end
    end

endmodule

// File: rtl/jk_flip_flop.sv
// Vectorised JK flip-flop: WIDTH independent cells, true and complementary outputs.
module jk_flip_flop
    import jk_pkg::*;
#(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_bit #(
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i])
        );
    end

    // Derived from q rather than stored, so the complement can never drift out of step.
    assign q_bar = ~q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed and randomised checks of jk_flip_flop at WIDTH=1 and WIDTH=4.
module tb_jk_flip_flop;

    logic       clk = 1'b0;
    logic       rst;
    logic       j_n, k_n;
    logic       q_n, q_bar_n;
    logic [3:0] j_w, k_w;
    logic [3:0] q_w, q_bar_w;
    logic [3:0] exp_w;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    jk_flip_flop #(.WIDTH(1)) dut_n (
        .clk   (clk),
        .rst   (rst),
        .j     (j_n),
        .k     (k_n),
        .q     (q_n),
        .q_bar (q_bar_n)
    );

    jk_flip_flop #(.WIDTH(4)) dut_w (
        .clk   (clk),
        .rst   (rst),
        .j     (j_w),
        .k     (k_w),
        .q     (q_w),
        .q_bar (q_bar_w)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Checks the narrow cell's q and its complement together.
    task automatic check_n(input string tag, input logic exp_q);
        check({tag, " q"},     {3'b000, q_n},     {3'b000, exp_q});
        check({tag, " q_bar"}, {3'b000, q_bar_n}, {3'b000, ~exp_q});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_next(input logic [3:0] cur, input logic [3:0] jv,
                                            input logic [3:0] kv);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) begin
            if (jv[b] && kv[b])  r[b] = !cur[b];
            else if (jv[b])      r[b] = 1'b1;
            else if (kv[b])      r[b] = 1'b0;
            else                 r[b] = cur[b];
        end
        return r;
    endfunction

    initial begin
        rst = 1'b0;
        j_n = 1'bx;
        k_n = 1'bx;
        j_w = 4'bxxxx;
        k_w = 4'bxxxx;

        #1 rst = 1'b1;
        #1;
        check_n("reset_async", 1'b0);
        check("reset_async_w q", q_w, 4'b0000);
        check("reset_async_w q_bar", q_bar_w, 4'b1111);

        tick();
        tick();
        check_n("reset_hold_x", 1'b0);

        j_n = 1'b1; k_n = 1'b1;
        tick();
        tick();
        check_n("reset_hold_tgl", 1'b0);

        rst = 1'b0;
        j_n = 1'b0; k_n = 1'b0;
        j_w = 4'b0000; k_w = 4'b0000;
        tick();
        check_n("hold_1", 1'b0);
        tick();
        check_n("hold_2", 1'b0);

        j_n = 1'b1; k_n = 1'b0;
        tick();
        check_n("set_from_0", 1'b1);
        j_n = 1'b0; k_n = 1'b1;
        tick();
        check_n("clr_from_1", 1'b0);

        j_n = 1'b1; k_n = 1'b1;
        tick(); check_n("toggle_1", 1'b1);
        tick(); check_n("toggle_2", 1'b0);
        tick(); check_n("toggle_3", 1'b1);
        tick(); check_n("toggle_4", 1'b0);

        tick();
        check_n("toggle_pre_rst", 1'b1);
        #3 rst = 1'b1;
        #1;
        check_n("rst_mid_cycle", 1'b0);
        tick();
        check_n("rst_hold_tgl", 1'b0);
        rst = 1'b0;
        tick();
        check_n("tgl_resume", 1'b1);

        j_n = 1'b0; k_n = 1'b1;
        tick();
        check_n("clr_before_race", 1'b0);
        j_n = 1'b1; k_n = 1'b0;
        @(posedge clk);
        rst = 1'b1;
        #1;
        check_n("rst_on_edge", 1'b0);
        rst = 1'b0;
        tick();
        check_n("set_after_race", 1'b1);

        check("wide_idle q", q_w, 4'b0000);
        j_w = 4'b0011; k_w = 4'b1100;
        tick();
        check("wide_load q", q_w, 4'b0011);
        j_w = 4'b1010; k_w = 4'b0110;
        tick();
        check("wide_vector q", q_w, 4'b1001);
        check("wide_vector q_bar", q_bar_w, 4'b0110);

        exp_w = 4'b1001;
        for (int n = 0; n < 200; n++) begin
            j_w = 4'($urandom_range(0, 15));
            k_w = 4'($urandom_range(0, 15));
            exp_w = ref_next(exp_w, j_w, k_w);
            tick();
            check("wide_random q", q_w, exp_w);
            check("wide_random q_bar", q_bar_w, ~exp_w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
